// File: rtl/output_unit.sv
// Output stage of one mesh-router port: owns the port for one packet at a
// time, buffers crossbar flits in a 4-entry FIFO and streams them to the
// neighbour over the push_x/push_ack link.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | port free, waiting for an allocation request
// S_GRANTED | port granted, waiting (bounded by TIMEOUT) for the head flit
// S_ACTIVE  | head accepted, taking body/tail flits
// S_DRAIN   | tail accepted, waiting for the tail to leave the FIFO
module output_unit #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vc_req,
    output logic        vc_grant,
    output logic        port_free,
    input  logic        xb_push,
    input  logic [63:0] xb_flit,
    output logic        st_ack,
    output logic [63:0] bf_out,
    output logic        push_x,
    input  logic        push_ack,
    output logic [2:0]  em_pl,
    output logic [7:0]  pkt_cnt,
    output logic        err
);

    typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_ACTIVE, S_DRAIN} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          grant_q, grant_d;
    logic          err_q, err_d;
    logic [7:0]    pkt_q, pkt_d;
    logic [2:0]    em_q, em_d;
    logic [1:0]    wr_q, wr_d;
    logic [1:0]    rd_q, rd_d;
    logic [63:0]   mem_q [DEPTH];

    logic [1:0]    flit_type;
    logic          legal;
    logic          fifo_empty;
    logic          pop;
    logic          tail_pop;

    assign flit_type  = xb_flit[63:62];
    assign legal      = (state_q == S_GRANTED && flit_type == 2'b11) ||
                        (state_q == S_ACTIVE  && (flit_type == 2'b01 || flit_type == 2'b10));
    assign fifo_empty = (em_q == 3'(DEPTH));
    // Acceptance looks only at the registered free count, so a full FIFO
    // never takes a flit in the same cycle one is leaving.
    assign st_ack     = reset & xb_push & (em_q != 3'd0) & legal;
    assign push_x     = ~fifo_empty;
    assign bf_out     = fifo_empty ? 64'h0 : mem_q[rd_q];
    assign pop        = push_x & push_ack;
    assign tail_pop   = pop & (bf_out[63:62] == 2'b10);

    assign vc_grant   = grant_q;
    assign port_free  = (state_q == S_IDLE);
    assign em_pl      = em_q;
    assign pkt_cnt    = pkt_q;
    assign err        = err_q;

    // Port-ownership FSM, grant pulse, head timeout and delivered-packet count.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        grant_d = 1'b0;
        pkt_d   = pkt_q;
        err_d   = err_q | (xb_push & ~legal);
        case (state_q)
            S_IDLE: begin
                if (vc_req) begin
                    state_d = S_GRANTED;
                    timer_d = TW'(TIMEOUT - 1);
                    grant_d = 1'b1;
                end
            end
            S_GRANTED: begin
                if (st_ack) begin
                    state_d = S_ACTIVE;
                end else if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_ACTIVE: begin
                if (st_ack && flit_type == 2'b10) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Only this packet's flits can be queued here, so the tail
                // leaving the FIFO means the packet is fully delivered.
                if (tail_pop) begin
                    state_d = S_IDLE;
                    pkt_d   = pkt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointer and free-slot bookkeeping.
    always_comb begin
        wr_d = wr_q + 2'(st_ack);
        rd_d = rd_q + 2'(pop);
        case ({st_ack, pop})
            2'b10:   em_d = em_q - 3'd1;
            2'b01:   em_d = em_q + 3'd1;
            default: em_d = em_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            grant_q <= 1'b0;
            err_q   <= 1'b0;
            pkt_q   <= 8'd0;
            em_q    <= 3'(DEPTH);
            wr_q    <= 2'd0;
            rd_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            pkt_q   <= pkt_d;
            em_q    <= em_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // FIFO storage; contents need no reset because bf_out is gated when empty.
    always_ff @(posedge clk) begin
        if (st_ack) begin
            mem_q[wr_q] <= xb_flit;
        end
    end

endmodule

// File: tb/tb_output_unit.sv
// Randomised bench for output_unit: a queue-based reference model predicts
// handshake/status outputs each cycle, and a separate monitor checks every
// flit leaving the port against a scoreboard of accepted flits.
module tb_output_unit;

    logic        clk = 1'b0;
    logic        reset, vc_req, xb_push, push_ack;
    logic [63:0] xb_flit;
    logic        vc_grant, port_free, st_ack, push_x, err;
    logic [63:0] bf_out;
    logic [2:0]  em_pl;
    logic [7:0]  pkt_cnt;

    always #5 clk = ~clk;

    output_unit #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .vc_req(vc_req), .vc_grant(vc_grant),
        .port_free(port_free), .xb_push(xb_push), .xb_flit(xb_flit),
        .st_ack(st_ack), .bf_out(bf_out), .push_x(push_x), .push_ack(push_ack),
        .em_pl(em_pl), .pkt_cnt(pkt_cnt), .err(err)
    );

    localparam int M_IDLE = 0, M_GRANT = 1, M_ACTIVE = 2, M_DRAIN = 3;

    int          n_checks = 0;
    int          n_err    = 0;
    bit          chk_on   = 0;
    int          m_state  = M_IDLE;
    int          m_gcyc   = 0;
    int          m_pkt    = 0;
    bit          m_grant  = 0;
    bit          m_err    = 0;
    bit          m_acc    = 0;
    logic [63:0] m_fifo[$];
    logic [63:0] exp_q[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(logic [1:0] t);
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[63:62] = t;
        return f;
    endfunction

    task automatic set_in(bit r, bit vr, bit xp, logic [63:0] f, bit pa);
        reset = r; vc_req = vc_req == vc_req ? vr : vr; xb_push = xp; xb_flit = f; push_ack = pa;
    endtask

    // Called just after a falling edge with inputs applied: check outputs
    // against the model, advance the model over the next rising edge.
    task automatic step();
        logic [1:0]  ty;
        logic [63:0] head;
        bit          legal, acc, pop;
        #2;
        ty    = xb_flit[63:62];
        legal = (ty == 2'b11 && m_state == M_GRANT) ||
                ((ty == 2'b01 || ty == 2'b10) && m_state == M_ACTIVE);
        acc   = (reset === 1'b1) && xb_push && legal && (m_fifo.size() < 4);
        if (chk_on) begin
            chk("st_ack", st_ack, acc);
            chk("em_pl", em_pl, 64'(4 - m_fifo.size()));
            chk("push_x", push_x, m_fifo.size() != 0);
            if (m_fifo.size() == 0) chk("bf_out_empty", bf_out, 64'h0);
            chk("port_free", port_free, m_state == M_IDLE);
            chk("vc_grant", vc_grant, m_grant);
            chk("err", err, m_err);
            chk("pkt_cnt", pkt_cnt, 64'(m_pkt));
        end
        m_acc = acc;
        if (reset !== 1'b1) begin
            m_state = M_IDLE; m_gcyc = 0; m_pkt = 0; m_grant = 0; m_err = 0;
            m_fifo.delete();
            exp_q.delete();
        end else begin
            pop     = (m_fifo.size() != 0) && push_ack;
            head    = (m_fifo.size() != 0) ? m_fifo[0] : 64'h0;
            m_grant = (m_state == M_IDLE) && vc_req;
            if (xb_push && !legal) m_err = 1;
            case (m_state)
                M_IDLE:   if (vc_req) begin m_state = M_GRANT; m_gcyc = 0; end
                M_GRANT: begin
                    m_gcyc++;
                    if (acc) m_state = M_ACTIVE;
                    else if (m_gcyc == 15) m_state = M_IDLE;
                end
                M_ACTIVE: if (acc && ty == 2'b10) m_state = M_DRAIN;
                M_DRAIN:  if (pop && head[63:62] == 2'b10) begin
                              m_state = M_IDLE;
                              m_pkt   = (m_pkt + 1) % 256;
                          end
                default:  m_state = M_IDLE;
            endcase
            if (pop) void'(m_fifo.pop_front());
            if (acc) begin
                m_fifo.push_back(xb_flit);
                exp_q.push_back(xb_flit);
            end
        end
        @(negedge clk);
    endtask

    // Scoreboard monitor: every flit handed downstream must be the oldest
    // accepted one still outstanding.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (chk_on && reset === 1'b1 && push_x === 1'b1 && push_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL scoreboard: actual flit %h required none at %0t", bf_out, $time);
                end else begin
                    chk("bf_out", bf_out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            set_in(1, 0, 0, 64'h0, 1);
            step();
        end
    endtask

    task automatic request();
        int k = 0;
        do begin
            set_in(1, 1, 0, 64'h0, 1);
            step();
            k++;
        end while (m_state != M_GRANT && k < 100);
        if (m_state != M_GRANT) begin
            n_checks++; n_err++;
            $display("FAIL request: actual no grant required grant within 100 cycles");
        end
    endtask

    task automatic push_until(logic [63:0] f, int ack_pct, bit gaps);
        int k = 0;
        bit done = 0;
        while (!done) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 15) == 0)
                    set_in(1, $urandom_range(0, 1) == 1, 1, mk(2'b00), $urandom_range(1, 100) <= ack_pct);
                else
                    set_in(1, $urandom_range(0, 1) == 1, 0, f, $urandom_range(1, 100) <= ack_pct);
            end else begin
                set_in(1, 0, 1, f, $urandom_range(1, 100) <= ack_pct);
            end
            step();
            if (m_acc) done = 1;
            k++;
            if (!done && k > 300) begin
                n_checks++; n_err++;
                $display("FAIL push_wait: actual not accepted required accepted within 300 cycles");
                done = 1;
            end
        end
    endtask

    task automatic drive_pkt(int nbody, int w, int ack_pct, bit gaps);
        request();
        idle(w);
        push_until(mk(2'b11), ack_pct, 0);
        repeat (nbody) push_until(mk(2'b01), ack_pct, gaps);
        push_until(mk(2'b10), ack_pct, gaps);
    endtask

    initial begin
        logic [63:0] f [6];
        set_in(0, 0, 0, 64'h0, 0);
        @(negedge clk);
        step();
        chk_on = 1;
        step();

        // Stray body flit while idle is a protocol error.
        set_in(1, 0, 1, mk(2'b01), 0);
        step();
        idle(1);
        set_in(0, 0, 0, 64'h0, 0);
        step();

        // Single 5-flit packet with downstream always ready.
        drive_pkt(3, 1, 100, 0);
        idle(4);

        // Backpressure: four flits fill the FIFO, the fifth waits.
        f[0] = mk(2'b11);
        for (int i = 1; i < 5; i++) f[i] = mk(2'b01);
        f[5] = mk(2'b10);
        request();
        idle(1);
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 1, f[i], 0);
            step();
        end
        push_until(f[4], 100, 0);
        push_until(f[5], 100, 0);
        idle(6);

        // One free slot held steady under simultaneous push and pop.
        request();
        set_in(1, 0, 1, mk(2'b11), 0); step();
        set_in(1, 0, 1, mk(2'b01), 0); step();
        set_in(1, 0, 1, mk(2'b01), 0); step();
        repeat (10) begin
            set_in(1, 0, 1, mk(2'b01), 1);
            step();
        end
        push_until(mk(2'b10), 100, 0);
        idle(5);

        // Grant timeout, with a second request ignored while granted.
        request();
        idle(4);
        set_in(1, 1, 0, 64'h0, 1); step();
        idle(14);

        // Head on the last allowed cycle, then one cycle too late.
        drive_pkt(1, 14, 100, 0);
        idle(5);
        request();
        idle(15);
        set_in(1, 0, 1, mk(2'b11), 1); step();
        idle(2);

        // Random traffic, enough packets to wrap the delivered counter.
        repeat (300) drive_pkt($urandom_range(0, 3), $urandom_range(0, 8), $urandom_range(20, 100), 1);
        idle(8);

        // Reset in the middle of a buffered packet.
        request();
        set_in(1, 0, 1, mk(2'b11), 0); step();
        set_in(1, 0, 1, mk(2'b01), 0); step();
        set_in(1, 0, 1, mk(2'b01), 0); step();
        set_in(0, 0, 0, 64'h0, 0); step();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual still running required finished by %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
        $fatal(1);
    end

endmodule

// File: doc/output_unit.md
# output_unit

Per-port output stage of the mesh router: the transmitting end of the flit link that feeds a neighbour's input unit. It accepts flits from the crossbar under a switch-traversal handshake and holds them in a 4-entry FIFO. It then drives them downstream using the `push_x`/`push_ack` handshake. It also owns the output port's allocation: exactly one packet (head…tail) at a time.

## Interface
Parameters
- `DEPTH`, 4: FIFO entries; `em_pl` width is fixed at 3 bits.
- `TIMEOUT`, 15: cycles a grant waits for its head flit before being revoked.

Ports
- `clk`  in  1  sole clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset, sampled on `clk`).
- `vc_req`  in  1  allocation request from an input unit holding a head flit.
- `vc_grant`  out  1  one-cycle grant pulse.
- `port_free`  out  1  1 when no packet owns the port.
- `xb_push`  in  1  crossbar flit valid.
- `xb_flit`  in  64  crossbar flit; [63:62] type: 11 head, 01 body, 10 tail, 00 invalid.
- `st_ack`  out  1  flit on `xb_flit` accepted this cycle (combinational).
- `bf_out`  out  64  flit to downstream `bf_in`.
- `push_x`  out  1  `bf_out` valid.
- `push_ack`  in  1  downstream took `bf_out` this cycle (may be combinational in `push_x`).
- `em_pl`  out  3  free FIFO slots, 0..4.
- `pkt_cnt`  out  8  packets fully delivered, wraps 255→0.
- `err`  out  1  sticky protocol-violation flag.

## Operation
- State machine:
  - IDLE: `port_free`=1. `vc_req`=1 → GRANTED, with `vc_grant`=1 registered for exactly that next cycle.
  - GRANTED: a head flit accepted → ACTIVE. A timer reaching `TIMEOUT` cycles with no head → IDLE.
  - ACTIVE: a tail flit accepted → DRAIN.
  - DRAIN: the tail popped downstream (`push_x`&`push_ack` with `bf_out`[63:62]=10) → IDLE in the same edge, and `pkt_cnt`+1.
- `vc_req` is ignored outside IDLE; no grant is queued.
- Accept rule: `st_ack` = `reset`&`xb_push`&(`em_pl`≠0)&type-legal.
  - Type-legal means: head only in GRANTED; body or tail only in ACTIVE.
  - An accepted flit is written at the FIFO tail.
- Any `xb_push` with an illegal type for the state, or type 00, is rejected: `st_ack`=0, flit dropped, `err`←1.
  - A push blocked only by a full FIFO is not an error.
- Transmit rule:
  - `push_x` = FIFO non-empty.
  - `bf_out` = FIFO head entry, or 64'h0 when empty.
  - Pop on `push_x`&`push_ack`.
  - `push_ack` while `push_x`=0 is ignored.
- `em_pl`: −1 on push only, +1 on pop only, unchanged on simultaneous push+pop. Acceptance uses the registered `em_pl`; there is no same-cycle pass-through at full.
- Read and write pointers are 2-bit and wrap modulo 4.
- A flit is forwarded unmodified; routing fields (dest X [8:6], Y [11:9]) are not inspected.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, FIFO emptied.
  - Outputs: `em_pl`=4, `push_x`=0, `bf_out`=0, `vc_grant`=0, `port_free`=1, `pkt_cnt`=0, `err`=0.
  - `st_ack`=0 combinationally while `reset`=0.
  - Reset mid-packet discards buffered flits; no tail is emitted.
- Grant latency: `vc_req` sampled at edge n → `vc_grant`=1 during cycle n+1 only.
  - A head can be accepted from cycle n+1.
- Flit latency: accepted at edge k → visible on `bf_out`/`push_x` in cycle k+1 at the earliest.
- Throughput: 1 flit/cycle in each direction when downstream acks every cycle.
- Timeout: the timer starts at 0 on entry to GRANTED. A head must be accepted by the `TIMEOUT`-th cycle in GRANTED; otherwise the state returns to IDLE at that edge.
- A tail accepted while earlier flits are still queued: DRAIN persists until that tail itself pops.

## Test plan
- Reset then idle: `reset`=0 for 2 cycles → `em_pl`=4, `push_x`=0, `port_free`=1, `pkt_cnt`=0; `xb_push` with a body flit → `st_ack`=0, `err`=1.
- Single 5-flit packet, downstream always acks: `vc_req` at cycle 0 → `vc_grant` at cycle 1; head, 3 bodies, tail pushed cycles 2–6 → `bf_out` matches in cycles 3–7, `pkt_cnt`=1, `port_free`=1 at cycle 8.
- Backpressure: `push_ack`=0 throughout → 4 flits accepted, `em_pl`=0, 5th `xb_push` gets `st_ack`=0, `err` stays 0. Release `push_ack` → all flits delivered in order.
- Simultaneous push+pop at `em_pl`=1 for 10 cycles → `em_pl` stays 1, order preserved.
- Grant timeout: `vc_req` with no head for 15 cycles → state IDLE and `port_free`=1. A second `vc_req` while GRANTED produces no second `vc_grant`.
- Counter wrap: deliver 256 packets → `pkt_cnt`=0. Assert `reset` mid-packet → FIFO cleared, `push_x`=0 next cycle.
